// File: rtl/sram_port_ctrl.sv
// Single-port SRAM front end: arbitrates a write and a read-request channel onto one array
// port and returns read data through a 2-entry in-order response buffer.
module sram_port_ctrl #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,

    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,

    output logic              rd_resp_valid,
    input  logic              rd_resp_ready,
    output logic [DATA_W-1:0] rd_resp_data,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_wmode,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    logic [1:0]        occ_q, occ_d;
    logic              inflight_q, inflight_d;
    logic              prio_rd_q, prio_rd_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] buf_q [2];
    logic [DATA_W-1:0] buf_d [2];
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic pop;
    logic eligible;
    logic conflict;
    logic wr_fire;
    logic rd_fire;

    always_comb begin
        rd_resp_valid = (occ_q != 2'd0);
        rd_resp_data  = buf_q[rd_ptr_q];
        pop           = rd_resp_valid && rd_resp_ready;

        // Slots committed = buffered + in flight; a pop this cycle frees one.
        eligible = (({1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2);
        conflict = wr_valid && rd_req_valid && eligible;

        wr_ready     = reset_n && !(rd_req_valid && eligible && prio_rd_q);
        rd_req_ready = reset_n && eligible && !(wr_valid && !prio_rd_q);

        wr_fire = wr_valid && wr_ready;
        rd_fire = rd_req_valid && rd_req_ready;

        mem_en    = wr_fire || rd_fire;
        mem_wmode = wr_fire;
        if (wr_fire) begin
            mem_addr = wr_addr;
        end else if (rd_fire) begin
            mem_addr = rd_req_addr;
        end else begin
            mem_addr = addr_q;
        end
        mem_wdata = wr_fire ? wr_data : wdata_q;

        busy = inflight_q || (occ_q != 2'd0);
    end

    always_comb begin
        addr_d     = mem_addr;
        wdata_d    = mem_wdata;
        inflight_d = rd_fire;
        prio_rd_d  = conflict ? !prio_rd_q : prio_rd_q;

        buf_d = buf_q;
        if (inflight_q) begin
            buf_d[wr_ptr_q] = mem_rdata;
        end
        wr_ptr_d = wr_ptr_q ^ inflight_q;
        rd_ptr_d = rd_ptr_q ^ pop;
        occ_d    = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            prio_rd_q  <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            prio_rd_q  <= prio_rd_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            buf_q[0]   <= buf_d[0];
            buf_q[1]   <= buf_d[1];
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

endmodule
